ram_loader: RTL
===============

// Module: ram_loader
// PURPOSE
//  Boot-time program loader and RAM bus owner, directly upstream of ram.
//  - Receives a length-prefixed byte stream on a valid/ready port and writes the payload to RAM from address 0.
//  - While loading it holds the CPU halted (cpu_run=0). After the load it hands the RAM bus to the CPU.
// PARAMETERS
//  addr_bits  16  RAM address width; must match ram.addr_bits (1..16)
//  data_bits  8   RAM word width; must match ram.data_bits; stream bytes are data_bits wide
// PORTS
//  clk             in   1          single clock; all state changes on posedge
//  rst_n           in   1          asynchronous, active-low reset
//  in_valid        in   1          stream byte present
//  in_ready        out  1          loader accepts byte this cycle
//  in_data         in   data_bits  stream byte
//  start           in   1          re-load request, honoured only in DONE
//  cpu_run         out  1          1 = CPU may execute; 0 = CPU held
//  load_error      out  1          sticky: header length exceeded RAM size
//  cpu_we          in   1          CPU write request (passed through in DONE)
//  cpu_address     in   addr_bits  CPU address (passed through in DONE)
//  cpu_data        in   data_bits  CPU write data (passed through in DONE)
//  ram_write_enable out 1          to ram.write_enable
//  ram_address     out  addr_bits  to ram.address
//  ram_data_in     out  data_bits  to ram.data_in
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=HDR_LO; in_ready=0 during reset; cpu_run=0; load_error=0.
//   - ram_write_enable=0, ram_address=0, ram_data_in=0; counters cleared.
//  Handshake: a byte transfers on posedge when in_valid && in_ready. in_ready is a registered-state decode, independent of in_valid.
//  Header: 16-bit little-endian payload length L (low byte first); data_bits=8 is assumed for the header.
//  States and transitions:
//   HDR_LO  ready=1; on transfer capture L[7:0] -> HDR_HI
//   HDR_HI  ready=1; on transfer capture L[15:8].
//           - If L==0 -> DONE.
//           - Else -> BYTE_WAIT; wr_addr=0, remaining=L.
//           - If L > 2**addr_bits, set load_error.
//   BYTE_WAIT ready=1; on transfer latch byte.
//           - If wr_addr < 2**addr_bits -> SETUP.
//           - Else drop the byte, decrement remaining, -> BYTE_WAIT, or -> DONE if remaining hits 0.
//   SETUP   ready=0; drive ram_address=wr_addr, ram_data_in=byte, ram_write_enable=0 -> WRITE
//   WRITE   ready=0; same address/data, ram_write_enable=1 (exactly one cycle).
//           - wr_addr++, remaining--.
//           - -> DONE if remaining==0, else BYTE_WAIT.
//   DONE    ready=0; cpu_run=1; ram_* = cpu_* combinationally. start=1 -> HDR_LO, cpu_run=0 next cycle.
//  Write timing:
//   - Address and data are stable one cycle before, during, and after each write_enable pulse. The ram is level-sensitive, so no glitches are allowed.
//   - ram_write_enable comes straight from a flop outside DONE.
//   - Throughput is 1 payload byte per 3 cycles minimum; in_valid gaps stall in BYTE_WAIT indefinitely.
//  Widths: wr_addr is addr_bits+1 wide, so its overflow bit marks "RAM full"; remaining is 16 bits. No wrap-around writes.
//  start outside DONE is ignored. load_error clears only on reset or on re-entry to HDR_LO via start.
//  Reset mid-load: immediate abort. Partially written RAM contents stay; they are not cleared.
// STRUCTURE
//  - ram_loader_pkg:
//    - typedef enum logic [2:0] loader_state_t {HDR_LO, HDR_HI, BYTE_WAIT, SETUP, WRITE, DONE}
//    - localparam HDR_BYTES=2
//    - localparam LEN_BITS=16
//  - Sub-module ram_bus_mux: combinational select between loader drive and cpu_* on sel=(state==DONE).
//  - Everything else (FSM, counters, latches) lives in ram_loader.
// TESTING
//  1. Stream 03 00 AA BB CC (L=3), in_valid held high:
//     - exactly 3 write pulses at addr 0,1,2 with data AA,BB,CC;
//     - cpu_run=1 on the cycle after the 3rd WRITE; ram holds AA BB CC.
//  2. Header 00 00:
//     - DONE two transfers after reset, no write pulse, cpu_run=1, load_error=0.
//  3. addr_bits=2, header 06 00 + 6 bytes 01..06:
//     - load_error=1;
//     - writes 01..04 at addr 0..3; 05,06 accepted (ready=1) and dropped;
//     - then DONE.
//  4. Random in_valid gaps (~50%) with L=5:
//     - ram_address/ram_data_in are stable around every ram_write_enable pulse;
//     - no byte is lost or duplicated.
//  5. rst_n low for 1 cycle during the 2nd payload byte's SETUP:
//     - all outputs at reset values immediately (async);
//     - the next stream 01 00 5A writes 5A at addr 0.
//  6. In DONE, drive cpu_we=1, cpu_address=7, cpu_data=3C:
//     - ram_* mirror them the same cycle;
//     - pulse start -> cpu_run=0, in_ready=1 on the next cycle, cpu_* no longer passed through.

Source files
------------

// File: rtl/ram_loader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ram_loader_pkg : shared types and constants for the RAM loader    |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package ram_loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO    = 3'd0,
    HDR_HI    = 3'd1,
    BYTE_WAIT = 3'd2,
    SETUP     = 3'd3,
    WRITE     = 3'd4,
    DONE      = 3'd5
  } loader_state_t;

  localparam int HDR_BYTES = 2;
  localparam int LEN_BITS  = 16;

  // States in which the stream port accepts a byte.
  function automatic logic accepts_bytes(input loader_state_t s);
    return (s == HDR_LO) || (s == HDR_HI) || (s == BYTE_WAIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_loader_ram_bus_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ram_bus_mux : selects RAM bus owner, loader or CPU                |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module ram_bus_mux #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 sel,
  input  logic                 ldr_we,
  input  logic [ADDR_BITS-1:0] ldr_address,
  input  logic [DATA_BITS-1:0] ldr_data,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_address,
  input  logic [DATA_BITS-1:0] cpu_data,
  output logic                 ram_write_enable,
  output logic [ADDR_BITS-1:0] ram_address,
  output logic [DATA_BITS-1:0] ram_data_in
);

  assign ram_write_enable = sel ? cpu_we      : ldr_we;
  assign ram_address      = sel ? cpu_address : ldr_address;
  assign ram_data_in      = sel ? cpu_data    : ldr_data;

endmodule
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ram_loader : length-prefixed stream loader, owns RAM until done   |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 start,
  output logic                 cpu_run,
  output logic                 load_error,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_address,
  input  logic [DATA_BITS-1:0] cpu_data,
  output logic                 ram_write_enable,
  output logic [ADDR_BITS-1:0] ram_address,
  output logic [DATA_BITS-1:0] ram_data_in
);

  localparam int          HDR_BITS  = HDR_BYTES * 8;
  localparam int unsigned RAM_WORDS = 32'd1 << ADDR_BITS;

  loader_state_t          state_q, state_d;
  logic                   ready_q, ready_d;
  logic [7:0]             len_lo_q, len_lo_d;
  logic [LEN_BITS-1:0]    remaining_q, remaining_d;
  logic [ADDR_BITS:0]     wr_addr_q, wr_addr_d;
  logic                   load_error_q, load_error_d;
  logic                   ldr_we_q, ldr_we_d;
  logic [ADDR_BITS-1:0]   ldr_addr_q, ldr_addr_d;
  logic [DATA_BITS-1:0]   ldr_data_q, ldr_data_d;

  logic                   w_xfer;
  logic [HDR_BITS-1:0]    w_hdr_len;

  assign w_xfer    = in_valid && ready_q;
  assign w_hdr_len = {in_data[7:0], len_lo_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HDR_LO;
      ready_q      <= 1'b0;
      len_lo_q     <= '0;
      remaining_q  <= '0;
      wr_addr_q    <= '0;
      load_error_q <= 1'b0;
      ldr_we_q     <= 1'b0;
      ldr_addr_q   <= '0;
      ldr_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      len_lo_q     <= len_lo_d;
      remaining_q  <= remaining_d;
      wr_addr_q    <= wr_addr_d;
      load_error_q <= load_error_d;
      ldr_we_q     <= ldr_we_d;
      ldr_addr_q   <= ldr_addr_d;
      ldr_data_q   <= ldr_data_d;
    end
  end

  // Address/data are captured on entry to SETUP and held until the next
  // byte, so they stay stable before, during and after the write pulse.
  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    remaining_d  = remaining_q;
    wr_addr_d    = wr_addr_q;
    load_error_d = load_error_q;
    ldr_we_d     = 1'b0;
    ldr_addr_d   = ldr_addr_q;
    ldr_data_d   = ldr_data_q;
    unique case (state_q)
      HDR_LO: begin
        if (w_xfer) begin
          len_lo_d = in_data[7:0];
          state_d  = HDR_HI;
        end
      end
      HDR_HI: begin
        if (w_xfer) begin
          if (32'(w_hdr_len) > RAM_WORDS) begin
            load_error_d = 1'b1;
          end
          if (w_hdr_len == '0) begin
            state_d = DONE;
          end else begin
            state_d     = BYTE_WAIT;
            wr_addr_d   = '0;
            remaining_d = w_hdr_len;
          end
        end
      end
      BYTE_WAIT: begin
        if (w_xfer) begin
          if (!wr_addr_q[ADDR_BITS]) begin
            ldr_addr_d = wr_addr_q[ADDR_BITS-1:0];
            ldr_data_d = in_data;
            state_d    = SETUP;
          end else begin
            // RAM full: consume and discard the byte.
            remaining_d = remaining_q - LEN_BITS'(1);
            state_d     = (remaining_q == LEN_BITS'(1)) ? DONE : BYTE_WAIT;
          end
        end
      end
      SETUP: begin
        ldr_we_d = 1'b1;
        state_d  = WRITE;
      end
      WRITE: begin
        wr_addr_d   = wr_addr_q + (ADDR_BITS + 1)'(1);
        remaining_d = remaining_q - LEN_BITS'(1);
        state_d     = (remaining_q == LEN_BITS'(1)) ? DONE : BYTE_WAIT;
      end
      DONE: begin
        if (start) begin
          state_d      = HDR_LO;
          load_error_d = 1'b0;
        end
      end
      default: begin
        state_d = HDR_LO;
      end
    endcase
    ready_d = accepts_bytes(state_d);
  end

  assign in_ready   = ready_q;
  assign cpu_run    = (state_q == DONE);
  assign load_error = load_error_q;

  ram_bus_mux #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_ram_bus_mux (
    .sel              (cpu_run),
    .ldr_we           (ldr_we_q),
    .ldr_address      (ldr_addr_q),
    .ldr_data         (ldr_data_q),
    .cpu_we           (cpu_we),
    .cpu_address      (cpu_address),
    .cpu_data         (cpu_data),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in)
  );

endmodule
`default_nettype wire
